// File: rtl/truth_table_sequencer_if.sv
// Bus between the truth-table sequencer and its driver/observer: sweep control,
// gate stimulus/response and the result registers.
interface truth_table_sequencer_if #(
  parameter int unsigned N_IN = 2
) ();
  localparam int unsigned NV = 1 << N_IN;

  logic                start;
  logic                abort;
  logic [N_IN-1:0]     gate_in;
  logic                gate_y;
  logic                busy;
  logic                done;
  logic                pass;
  logic [NV-1:0]       err_mask;
  logic [N_IN:0]       err_count;

  // Sequencer side
  modport slave (
    input  start, abort, gate_y,
    output gate_in, busy, done, pass, err_mask, err_count
  );

  // Controller / environment side
  modport master (
    output start, abort, gate_y,
    input  gate_in, busy, done, pass, err_mask, err_count
  );
endinterface

// File: rtl/truth_table_sequencer.sv
// Truth-table sequencer: walks a combinational gate through every input vector
// in ascending order, waits SETTLE cycles per vector, samples the gate output
// and records mismatches against the expected truth table.
module truth_table_sequencer #(
  parameter int unsigned            N_IN   = 2,
  parameter logic [(1<<N_IN)-1:0]   TRUTH  = 4'b1000,
  parameter int unsigned            SETTLE = 2
) (
  input logic                   clk,
  input logic                   rst,
  truth_table_sequencer_if.slave bus
);
  localparam int unsigned NV = 1 << N_IN;
  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NV - 1);
  localparam logic [CW-1:0]   CNT_INIT = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE_ST = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state, state_next;
  logic [N_IN-1:0] vec, vec_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [N_IN-1:0] gate_in_next;
  logic            pass_next;
  logic [NV-1:0]   mask_next;
  logic [N_IN:0]   count_next;

  // Next-state and next-datapath decode
  always_comb begin
    state_next   = state;
    vec_next     = vec;
    cnt_next     = cnt;
    gate_in_next = bus.gate_in;
    pass_next    = bus.pass;
    mask_next    = bus.err_mask;
    count_next   = bus.err_count;

    case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          gate_in_next = '0;
          vec_next     = '0;
          cnt_next     = CNT_INIT;
          mask_next    = '0;
          count_next   = '0;
          pass_next    = 1'b0;
          state_next   = SETTLE_ST;
        end
      end
      SETTLE_ST: begin
        if (bus.abort) begin
          gate_in_next = '0;
          pass_next    = 1'b0;
          state_next   = IDLE;
        end else if (cnt == '0) begin
          state_next = SAMPLE;
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      SAMPLE: begin
        if (bus.abort) begin
          // Comparison for this vector is dropped on abort
          gate_in_next = '0;
          pass_next    = 1'b0;
          state_next   = IDLE;
        end else begin
          if (bus.gate_y != TRUTH[vec]) begin
            mask_next[vec] = 1'b1;
            count_next     = bus.err_count + 1'b1;
          end
          if (vec == LAST_VEC) begin
            gate_in_next = '0;
            state_next   = DONE;
          end else begin
            vec_next     = vec + 1'b1;
            gate_in_next = vec + 1'b1;
            cnt_next     = CNT_INIT;
            state_next   = SETTLE_ST;
          end
        end
      end
      DONE: begin
        pass_next  = bus.abort ? 1'b0 : (bus.err_count == '0);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, datapath and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      vec           <= '0;
      cnt           <= '0;
      bus.gate_in   <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.pass      <= 1'b0;
      bus.err_mask  <= '0;
      bus.err_count <= '0;
    end else begin
      state         <= state_next;
      vec           <= vec_next;
      cnt           <= cnt_next;
      bus.gate_in   <= gate_in_next;
      bus.busy      <= (state_next == SETTLE_ST) || (state_next == SAMPLE);
      bus.done      <= (state_next == DONE);
      bus.pass      <= pass_next;
      bus.err_mask  <= mask_next;
      bus.err_count <= count_next;
    end
  end
endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: three instances (default AND, OR-expected
// with AND wired, 3-input AND with SETTLE=1) checked against a timing/result
// model derived from the sweep rules.
module tb_truth_table_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic       start_v [3];
  logic       abort_v [3];
  logic [3:0] tbl0;

  truth_table_sequencer_if #(.N_IN(2)) b0 ();
  truth_table_sequencer_if #(.N_IN(2)) b1 ();
  truth_table_sequencer_if #(.N_IN(3)) b2 ();

  truth_table_sequencer #(.N_IN(2), .TRUTH(4'b1000), .SETTLE(2)) u0 (.clk(clk), .rst(rst), .bus(b0));
  truth_table_sequencer #(.N_IN(2), .TRUTH(4'b1110), .SETTLE(2)) u1 (.clk(clk), .rst(rst), .bus(b1));
  truth_table_sequencer #(.N_IN(3), .TRUTH(8'b1000_0000), .SETTLE(1)) u2 (.clk(clk), .rst(rst), .bus(b2));

  assign b0.start = start_v[0];
  assign b1.start = start_v[1];
  assign b2.start = start_v[2];
  assign b0.abort = abort_v[0];
  assign b1.abort = abort_v[1];
  assign b2.abort = abort_v[2];
  assign b0.gate_y = tbl0[b0.gate_in];
  assign b1.gate_y = &b1.gate_in;
  assign b2.gate_y = &b2.gate_in;

  logic [3:0] o_gin  [3];
  logic       o_busy [3];
  logic       o_done [3];
  logic       o_pass [3];
  logic [7:0] o_mask [3];
  logic [3:0] o_cnt  [3];

  assign o_gin[0] = 4'(b0.gate_in);  assign o_gin[1] = 4'(b1.gate_in);  assign o_gin[2] = 4'(b2.gate_in);
  assign o_busy[0] = b0.busy;        assign o_busy[1] = b1.busy;        assign o_busy[2] = b2.busy;
  assign o_done[0] = b0.done;        assign o_done[1] = b1.done;        assign o_done[2] = b2.done;
  assign o_pass[0] = b0.pass;        assign o_pass[1] = b1.pass;        assign o_pass[2] = b2.pass;
  assign o_mask[0] = 8'(b0.err_mask); assign o_mask[1] = 8'(b1.err_mask); assign o_mask[2] = 8'(b2.err_mask);
  assign o_cnt[0] = 4'(b0.err_count); assign o_cnt[1] = 4'(b1.err_count); assign o_cnt[2] = 4'(b2.err_count);

  // All outputs of instance d must be zero
  task automatic test_reset(input int d, input string tag);
    total++; if (o_gin[d] !== 4'd0) begin bad++; $display("FAIL %s gate_in d%0d got=%0d exp=0", tag, d, o_gin[d]); end
    total++; if (o_busy[d] !== 1'b0) begin bad++; $display("FAIL %s busy d%0d got=%b exp=0", tag, d, o_busy[d]); end
    total++; if (o_done[d] !== 1'b0) begin bad++; $display("FAIL %s done d%0d got=%b exp=0", tag, d, o_done[d]); end
    total++; if (o_pass[d] !== 1'b0) begin bad++; $display("FAIL %s pass d%0d got=%b exp=0", tag, d, o_pass[d]); end
    total++; if (o_mask[d] !== 8'd0) begin bad++; $display("FAIL %s err_mask d%0d got=%b exp=0", tag, d, o_mask[d]); end
    total++; if (o_cnt[d] !== 4'd0) begin bad++; $display("FAIL %s err_count d%0d got=%0d exp=0", tag, d, o_cnt[d]); end
  endtask

  // Full sweep on instance d; 'actual' is the truth table the wired gate really implements.
  // spur>=0 pulses start after edge spur (sampled while busy or in DONE, must be ignored).
  task automatic run_sweep(input int d, input int nin, input int st, input logic [7:0] truth,
                           input logic [7:0] actual, input int spur);
    int nv, len;
    logic [7:0] em, vmask;
    logic [3:0] ec, eg;
    logic eb, ed, ep;
    nv = 1 << nin;
    len = nv * (st + 1);
    vmask = 8'((1 << nv) - 1);
    em = (truth ^ actual) & vmask;
    ec = 4'($countones(em));
    if (d == 0) tbl0 = actual[3:0];
    start_v[d] = 1'b1;
    for (int k = 0; k <= len + 1; k++) begin
      @(posedge clk); #1;
      start_v[d] = 1'b0;
      eg = (k < len) ? 4'(k / (st + 1)) : 4'd0;
      eb = (k < len);
      ed = (k == len);
      ep = (k == len + 1) ? (ec == 4'd0) : 1'b0;
      total++; if (o_gin[d] !== eg) begin bad++; $display("FAIL sweep_gate_in d%0d k=%0d got=%0d exp=%0d", d, k, o_gin[d], eg); end
      total++; if (o_busy[d] !== eb) begin bad++; $display("FAIL sweep_busy d%0d k=%0d got=%b exp=%b", d, k, o_busy[d], eb); end
      total++; if (o_done[d] !== ed) begin bad++; $display("FAIL sweep_done d%0d k=%0d got=%b exp=%b", d, k, o_done[d], ed); end
      total++; if (o_pass[d] !== ep) begin bad++; $display("FAIL sweep_pass d%0d k=%0d got=%b exp=%b", d, k, o_pass[d], ep); end
      if (k == 0) begin
        total++; if (o_mask[d] !== 8'd0) begin bad++; $display("FAIL accept_clear_mask d%0d got=%b exp=0", d, o_mask[d]); end
        total++; if (o_cnt[d] !== 4'd0) begin bad++; $display("FAIL accept_clear_count d%0d got=%0d exp=0", d, o_cnt[d]); end
      end
      if (k == len + 1) begin
        total++; if (o_mask[d] !== em) begin bad++; $display("FAIL result_mask d%0d got=%b exp=%b", d, o_mask[d], em); end
        total++; if (o_cnt[d] !== ec) begin bad++; $display("FAIL result_count d%0d got=%0d exp=%0d", d, o_cnt[d], ec); end
      end
      if (k == spur) start_v[d] = 1'b1;
    end
    @(posedge clk); #1;
    start_v[d] = 1'b0;
    total++; if (o_busy[d] !== 1'b0) begin bad++; $display("FAIL no_restart_busy d%0d got=%b exp=0", d, o_busy[d]); end
    total++; if (o_mask[d] !== em) begin bad++; $display("FAIL hold_mask d%0d got=%b exp=%b", d, o_mask[d], em); end
  endtask

  task automatic test_and_correct();
    run_sweep(0, 2, 2, 8'h08, 8'h08, -1);
  endtask

  task automatic test_tied();
    run_sweep(0, 2, 2, 8'h08, 8'h00, -1);
    run_sweep(0, 2, 2, 8'h08, 8'h0F, -1);
  endtask

  task automatic test_or_expected();
    run_sweep(1, 2, 2, 8'h0E, 8'h08, -1);
    run_sweep(1, 2, 2, 8'h0E, 8'h08, 4);
  endtask

  task automatic test_three_input();
    run_sweep(2, 3, 1, 8'h80, 8'h80, -1);
  endtask

  task automatic test_random();
    logic [7:0] act;
    int sp;
    for (int i = 0; i < 6; i++) begin
      act = 8'($urandom_range(0, 15));
      sp = int'($urandom_range(1, 12));
      run_sweep(0, 2, 2, 8'h08, act, sp);
    end
  endtask

  // Abort sampled at edge a after the start edge; every vector mismatches so
  // err_mask shows exactly which comparisons completed before the abort.
  task automatic test_abort(input int a);
    logic [3:0] em, ec;
    em = 4'd0;
    for (int v = 0; v < 4; v++) if ((v + 1) * 3 < a) em[v] = 1'b1;
    ec = 4'($countones(em));
    tbl0 = 4'b0111;
    start_v[0] = 1'b1;
    for (int k = 0; k <= a; k++) begin
      @(posedge clk); #1;
      start_v[0] = 1'b0;
      if (k == a - 1) abort_v[0] = 1'b1;
    end
    abort_v[0] = 1'b0;
    total++; if (o_busy[0] !== 1'b0) begin bad++; $display("FAIL abort_busy a=%0d got=%b exp=0", a, o_busy[0]); end
    total++; if (o_gin[0] !== 4'd0) begin bad++; $display("FAIL abort_gate_in a=%0d got=%0d exp=0", a, o_gin[0]); end
    total++; if (o_pass[0] !== 1'b0) begin bad++; $display("FAIL abort_pass a=%0d got=%b exp=0", a, o_pass[0]); end
    total++; if (o_mask[0] !== {4'd0, em}) begin bad++; $display("FAIL abort_mask a=%0d got=%b exp=%b", a, o_mask[0], em); end
    total++; if (o_cnt[0] !== ec) begin bad++; $display("FAIL abort_count a=%0d got=%0d exp=%0d", a, o_cnt[0], ec); end
    for (int k = 0; k < 4; k++) begin
      total++; if (o_done[0] !== 1'b0) begin bad++; $display("FAIL abort_no_done a=%0d k=%0d got=%b exp=0", a, k, o_done[0]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_start_abort_idle();
    start_v[0] = 1'b1;
    abort_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    abort_v[0] = 1'b0;
    total++; if (o_busy[0] !== 1'b0) begin bad++; $display("FAIL start_abort_idle busy got=%b exp=0", o_busy[0]); end
    @(posedge clk); #1;
    total++; if (o_busy[0] !== 1'b0) begin bad++; $display("FAIL start_abort_idle busy2 got=%b exp=0", o_busy[0]); end
  endtask

  task automatic test_async_reset();
    tbl0 = 4'b0111;
    start_v[0] = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      @(posedge clk); #1;
      start_v[0] = 1'b0;
    end
    total++; if (o_gin[0] !== 4'd2) begin bad++; $display("FAIL pre_reset_gate_in got=%0d exp=2", o_gin[0]); end
    total++; if (o_mask[0] !== 8'h03) begin bad++; $display("FAIL pre_reset_mask got=%b exp=00000011", o_mask[0]); end
    #2 rst = 1'b1;
    #1 test_reset(0, "async_reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    test_reset(0, "post_reset");
    run_sweep(0, 2, 2, 8'h08, 8'h08, -1);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin start_v[i] = 1'b0; abort_v[i] = 1'b0; end
    tbl0 = 4'b1000;
    repeat (2) @(posedge clk);
    #1;
    test_reset(0, "reset");
    test_reset(2, "reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    test_and_correct();
    test_tied();
    test_or_expected();
    test_three_input();
    test_abort(5);
    test_abort(12);
    for (int i = 0; i < 3; i++) test_abort(int'($urandom_range(1, 12)));
    test_start_abort_idle();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/truth_table_sequencer.md
Name: truth_table_sequencer

Overview:
- Self-checking controller that sequences a small combinational gate under test (the lab's AND/OR/XOR gate modules).
- Walks the gate's inputs through every input combination in ascending binary order.
- Waits a programmable settle time after each vector, samples the gate output and compares it against an expected truth table.
- Reports per-vector mismatches, a mismatch count, a pass flag and a one-cycle done pulse.
- Replaces hand-written per-gate stimulus blocks with one reusable hardware checker.

Parameters:
- N_IN, 2, number of gate inputs (legal 1..4).
- TRUTH, 4'b1000, expected output per input vector, 2**N_IN bits; bit v = expected y when gate_in == v (default = 2-input AND).
- SETTLE, 2, cycles gate_in is held before sampling (legal >= 1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a sweep; sampled only in IDLE.
- abort  input  1  terminate a sweep; effective in any state.
- gate_in  output  N_IN  registered stimulus to gate under test.
- gate_y  input  1  gate under test output.
- busy  output  1  high in SETTLE and SAMPLE.
- done  output  1  one-cycle pulse at end of a completed sweep.
- pass  output  1  last completed sweep had zero mismatches.
- err_mask  output  2**N_IN  bit v set if vector v mismatched.
- err_count  output  N_IN+1  number of mismatching vectors.

Behaviour:
- One clock; reset is asynchronous and active-high. While rst is high: state=IDLE; gate_in, busy, done, pass, err_mask, err_count and the internal vector and settle counters are all 0, applied immediately including mid-sweep.
- States: IDLE, SETTLE, SAMPLE, DONE. busy = (SETTLE or SAMPLE); done = (state == DONE), Moore.
- IDLE, start=1, abort=0: gate_in<=0, vec<=0, cnt<=SETTLE-1, err_mask<=0, err_count<=0, pass<=0, go to SETTLE.
- SETTLE: if cnt==0 go to SAMPLE, else cnt<=cnt-1. SETTLE therefore lasts exactly SETTLE cycles.
- SAMPLE (1 cycle): at the exiting edge, compare gate_y against TRUTH[vec].
  - On mismatch: err_mask[vec]<=1 and err_count<=err_count+1.
  - If vec == 2**N_IN-1: gate_in<=0 and go to DONE.
  - Otherwise: vec<=vec+1, gate_in<=vec+1, cnt<=SETTLE-1, go to SETTLE.
- DONE (1 cycle): pass<=(final err_count==0), go to IDLE.
- Timing: with start sampled at edge 0, vector v is driven from edge v*(SETTLE+1). done is high for the cycle following edge 2**N_IN*(SETTLE+1). Defaults give 12 cycles.
- pass, err_mask and err_count hold their values after DONE until the next accepted start.
- start while busy or in DONE: ignored.
- abort in SETTLE, SAMPLE or DONE:
  - Next edge: state=IDLE, gate_in=0, pass=0.
  - No done pulse.
  - err_mask and err_count keep partial results.
  - A comparison due on that edge is discarded.
- start and abort together in IDLE: abort wins; remain in IDLE.
- The vector counter never wraps: the sweep terminates after the last vector.

Test Plan:
- Default params, correct AND wired to gate_in/gate_y, pulse start: gate_in steps 0,1,2,3 every 3 cycles; done pulses 12 cycles after start edge; pass=1, err_mask=4'b0000, err_count=0.
- gate_y tied 0: err_mask=4'b1000, err_count=1, pass=0. gate_y tied 1: err_mask=4'b0111, err_count=3, pass=0.
- TRUTH=4'b1110 (OR expected) with AND wired: err_mask=4'b0110, err_count=2, pass=0. A subsequent start clears all three outputs on acceptance.
- SETTLE=1, N_IN=3, TRUTH=8'b1000_0000, 3-input AND: done 16 cycles after start; pass=1.
- Abort 5 cycles after start: busy=0 and gate_in=0 next cycle; no done pulse; pass=0. start pulsed while busy produces no restart (vector sequence unbroken).
- Assert rst asynchronously mid-SETTLE of vector 2 (between clock edges): all outputs 0 immediately. After release, start yields a full 12-cycle sweep.
